// File: rtl/rocc_cmd_initiator.sv
// rocc_cmd_initiator: RoCC command issuer with rd-tagged response tracking, latency and timeouts
module rocc_cmd_initiator #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int LAT_WIDTH = 32
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [6:0]                         req_funct,
  input  logic [4:0]                         req_rs1_idx,
  input  logic [4:0]                         req_rs2_idx,
  input  logic [4:0]                         req_rd,
  input  logic [6:0]                         req_opcode,
  input  logic                               req_xd,
  input  logic [63:0]                        req_rs1,
  input  logic [63:0]                        req_rs2,
  output logic                               io_cmd_valid,
  input  logic                               io_cmd_ready,
  output logic [6:0]                         io_cmd_bits_inst_funct,
  output logic [4:0]                         io_cmd_bits_inst_rs2,
  output logic [4:0]                         io_cmd_bits_inst_rs1,
  output logic [4:0]                         io_cmd_bits_inst_rd,
  output logic [6:0]                         io_cmd_bits_inst_opcode,
  output logic [63:0]                        io_cmd_bits_rs1,
  output logic [63:0]                        io_cmd_bits_rs2,
  input  logic                               io_resp_valid,
  output logic                               io_resp_ready,
  input  logic [4:0]                         io_resp_bits_rd,
  input  logic [63:0]                        io_resp_bits_data,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [4:0]                         res_rd,
  output logic [63:0]                        res_data,
  output logic [LAT_WIDTH-1:0]               res_latency,
  output logic                               res_error,
  output logic                               timeout_pulse,
  output logic                               err_sticky,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);
  localparam int N = MAX_OUTSTANDING;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int OW = $clog2(N + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;
  logic [0:0] state_q, state_d;
  logic [LAT_WIDTH-1:0] now_q;
  logic [N-1:0] v_q, iss_q;
  logic [4:0] rd_q [N];
  logic [LAT_WIDTH-1:0] ts_q [N];
  logic [IW-1:0] cmd_idx_q, free_idx, hit_idx, to_idx;
  logic cmd_xd_q, has_free, dup, hit, to_hit;
  logic req_fire, cmd_fire, resp_fire, alloc;
  assign req_ready = state_q == IDLE && (!req_xd || (has_free && !dup));
  assign req_fire = req_valid && req_ready;
  assign io_cmd_valid = state_q == ISSUE;
  assign cmd_fire = io_cmd_valid && io_cmd_ready;
  assign io_resp_ready = !res_valid || res_ready;
  assign resp_fire = io_resp_valid && io_resp_ready;
  assign alloc = req_fire && req_xd;
  assign timeout_pulse = to_hit;
  assign state_d = req_fire ? ISSUE : cmd_fire ? IDLE : state_q;
  // table lookups: lowest free slot, rd duplicate, response match, oldest-index timeout
  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    dup = 1'b0;
    hit = 1'b0;
    hit_idx = '0;
    to_hit = 1'b0;
    to_idx = '0;
    outstanding = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!v_q[i]) begin
        has_free = 1'b1;
        free_idx = IW'(i);
      end
      if (v_q[i] && rd_q[i] == req_rd) dup = 1'b1;
      if (iss_q[i] && rd_q[i] == io_resp_bits_rd) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
      outstanding += OW'(v_q[i]);
    end
    hit = hit && resp_fire;
    for (int i = N - 1; i >= 0; i--)
      if (iss_q[i] && !(hit && hit_idx == IW'(i)) && now_q - ts_q[i] >= LAT_WIDTH'(TIMEOUT_CYCLES)) begin
        to_hit = 1'b1;
        to_idx = IW'(i);
      end
    to_hit = to_hit && !reset;
  end
  // command register, tracking table, result register and error flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      now_q <= '0;
      v_q <= '0;
      iss_q <= '0;
      cmd_idx_q <= '0;
      cmd_xd_q <= 1'b0;
      io_cmd_bits_inst_funct <= '0;
      io_cmd_bits_inst_rs2 <= '0;
      io_cmd_bits_inst_rs1 <= '0;
      io_cmd_bits_inst_rd <= '0;
      io_cmd_bits_inst_opcode <= '0;
      io_cmd_bits_rs1 <= '0;
      io_cmd_bits_rs2 <= '0;
      res_valid <= 1'b0;
      res_rd <= '0;
      res_data <= '0;
      res_latency <= '0;
      res_error <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      now_q <= now_q + 1'b1;
      state_q <= state_d;
      if (req_fire) begin
        io_cmd_bits_inst_funct <= req_funct;
        io_cmd_bits_inst_rs2 <= req_rs2_idx;
        io_cmd_bits_inst_rs1 <= req_rs1_idx;
        io_cmd_bits_inst_rd <= req_rd;
        io_cmd_bits_inst_opcode <= req_opcode;
        io_cmd_bits_rs1 <= req_rs1;
        io_cmd_bits_rs2 <= req_rs2;
        cmd_xd_q <= req_xd;
        cmd_idx_q <= free_idx;
      end
      for (int i = 0; i < N; i++) begin
        if (alloc && free_idx == IW'(i)) begin
          v_q[i] <= 1'b1;
          iss_q[i] <= 1'b0;
          rd_q[i] <= req_rd;
        end
        if (cmd_fire && cmd_xd_q && cmd_idx_q == IW'(i)) begin
          iss_q[i] <= 1'b1;
          ts_q[i] <= now_q;
        end
        if ((hit && hit_idx == IW'(i)) || (to_hit && to_idx == IW'(i))) begin
          v_q[i] <= 1'b0;
          iss_q[i] <= 1'b0;
        end
      end
      if (resp_fire) begin
        res_valid <= 1'b1;
        res_rd <= io_resp_bits_rd;
        res_data <= io_resp_bits_data;
        res_latency <= hit ? now_q - ts_q[hit_idx] : '0;
        res_error <= !hit;
      end else if (res_ready) res_valid <= 1'b0;
      if (to_hit || (resp_fire && !hit)) err_sticky <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rocc_cmd_initiator.sv
// tb_rocc_cmd_initiator: directed checks of issue, tracking, latency, errors, timeout and reset
module tb_rocc_cmd_initiator;
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 0, req_xd = 0, io_cmd_ready = 0, io_resp_valid = 0, res_ready = 1;
  logic [6:0] req_funct = 0, req_opcode = 0;
  logic [4:0] req_rs1_idx = 0, req_rs2_idx = 0, req_rd = 0, io_resp_bits_rd = 0;
  logic [63:0] req_rs1 = 0, req_rs2 = 0, io_resp_bits_data = 0;
  logic req_ready, io_cmd_valid, io_resp_ready, res_valid, res_error, timeout_pulse, err_sticky;
  logic [6:0] c_funct, c_opcode;
  logic [4:0] c_rs2, c_rs1, c_rd, res_rd;
  logic [63:0] c_rs1v, c_rs2v, res_data;
  logic [31:0] res_latency;
  logic [2:0] outstanding;
  logic t_req_ready, t_io_cmd_valid, t_io_resp_ready, t_res_valid, t_res_error, t_timeout_pulse, t_err_sticky;
  logic [6:0] t_c_funct, t_c_opcode;
  logic [4:0] t_c_rs2, t_c_rs1, t_c_rd, t_res_rd;
  logic [63:0] t_c_rs1v, t_c_rs2v, t_res_data;
  logic [31:0] t_res_latency;
  logic [2:0] t_outstanding;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  rocc_cmd_initiator dut (
    .clock(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct(req_funct), .req_rs1_idx(req_rs1_idx), .req_rs2_idx(req_rs2_idx), .req_rd(req_rd),
    .req_opcode(req_opcode), .req_xd(req_xd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .io_cmd_valid(io_cmd_valid), .io_cmd_ready(io_cmd_ready),
    .io_cmd_bits_inst_funct(c_funct), .io_cmd_bits_inst_rs2(c_rs2), .io_cmd_bits_inst_rs1(c_rs1),
    .io_cmd_bits_inst_rd(c_rd), .io_cmd_bits_inst_opcode(c_opcode),
    .io_cmd_bits_rs1(c_rs1v), .io_cmd_bits_rs2(c_rs2v),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_bits_rd(io_resp_bits_rd), .io_resp_bits_data(io_resp_bits_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_rd(res_rd), .res_data(res_data),
    .res_latency(res_latency), .res_error(res_error), .timeout_pulse(timeout_pulse),
    .err_sticky(err_sticky), .outstanding(outstanding)
  );
  rocc_cmd_initiator #(.TIMEOUT_CYCLES(16)) dut16 (
    .clock(clk), .reset(reset), .req_valid(req_valid), .req_ready(t_req_ready),
    .req_funct(req_funct), .req_rs1_idx(req_rs1_idx), .req_rs2_idx(req_rs2_idx), .req_rd(req_rd),
    .req_opcode(req_opcode), .req_xd(req_xd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .io_cmd_valid(t_io_cmd_valid), .io_cmd_ready(io_cmd_ready),
    .io_cmd_bits_inst_funct(t_c_funct), .io_cmd_bits_inst_rs2(t_c_rs2), .io_cmd_bits_inst_rs1(t_c_rs1),
    .io_cmd_bits_inst_rd(t_c_rd), .io_cmd_bits_inst_opcode(t_c_opcode),
    .io_cmd_bits_rs1(t_c_rs1v), .io_cmd_bits_rs2(t_c_rs2v),
    .io_resp_valid(io_resp_valid), .io_resp_ready(t_io_resp_ready),
    .io_resp_bits_rd(io_resp_bits_rd), .io_resp_bits_data(io_resp_bits_data),
    .res_valid(t_res_valid), .res_ready(res_ready), .res_rd(t_res_rd), .res_data(t_res_data),
    .res_latency(t_res_latency), .res_error(t_res_error), .timeout_pulse(t_timeout_pulse),
    .err_sticky(t_err_sticky), .outstanding(t_outstanding)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic send_cmd(input logic [4:0] rd, input logic xd);
    req_valid = 1'b1;
    req_rd = rd;
    req_xd = xd;
    #1;
    for (int k = 0; k < 20 && !req_ready; k++) tick();
    chk("req_ready_wait", req_ready, 1);
    tick();
    req_valid = 1'b0;
    io_cmd_ready = 1'b1;
    tick();
    io_cmd_ready = 1'b0;
  endtask
  task automatic respond(input logic [4:0] rd, input logic [63:0] data);
    io_resp_valid = 1'b1;
    io_resp_bits_rd = rd;
    io_resp_bits_data = data;
    tick();
    io_resp_valid = 1'b0;
  endtask
  initial begin
    do_reset();
    chk("rst_outstanding", outstanding, 0);
    chk("rst_cmd_valid", io_cmd_valid, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_err_sticky", err_sticky, 0);
    chk("rst_timeout", timeout_pulse, 0);
    // single command with a stalled accelerator and a 500-cycle response
    req_valid = 1; req_rd = 5; req_xd = 1; req_rs1 = 64'h10; req_rs2 = 64'h20;
    req_funct = 7'h03; req_opcode = 7'h0b; req_rs1_idx = 1; req_rs2_idx = 2;
    #1;
    chk("single_req_ready", req_ready, 1);
    tick();
    req_valid = 0; req_rs1 = 64'hdead; req_rd = 0; req_funct = 0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_cmd_valid", io_cmd_valid, 1);
      chk("stall_rs1", c_rs1v, 64'h10);
      chk("stall_bits", {c_funct, c_rs2, c_rs1, c_rd, c_opcode}, {7'h03, 5'd2, 5'd1, 5'd5, 7'h0b});
      tick();
    end
    chk("single_outstanding", outstanding, 1);
    io_cmd_ready = 1;
    tick();
    io_cmd_ready = 0;
    chk("after_fire_cmd_valid", io_cmd_valid, 0);
    repeat (499) tick();
    respond(5, 64'd6);
    chk("single_res_valid", res_valid, 1);
    chk("single_res_rd", res_rd, 5);
    chk("single_res_data", res_data, 6);
    chk("single_res_latency", res_latency, 500);
    chk("single_res_error", res_error, 0);
    chk("single_outstanding_0", outstanding, 0);
    // fill the table, stall a fifth request until a slot frees
    for (int r = 1; r <= 4; r++) send_cmd(5'(r), 1'b1);
    chk("fill_outstanding", outstanding, 4);
    req_valid = 1; req_rd = 7; req_xd = 1;
    #1;
    chk("full_req_ready", req_ready, 0);
    tick();
    chk("full_req_ready_2", req_ready, 0);
    respond(2, 64'h22);
    chk("fill_res_rd", res_rd, 2);
    chk("fill_res_error", res_error, 0);
    chk("fill_outstanding_3", outstanding, 3);
    chk("fill_req_ready_next", req_ready, 1);
    tick();
    req_valid = 0;
    io_cmd_ready = 1;
    tick();
    io_cmd_ready = 0;
    chk("fill_outstanding_4", outstanding, 4);
    // duplicate rd stalls until that rd's response fires
    respond(1, 0);
    respond(4, 0);
    respond(7, 0);
    chk("dup_outstanding_1", outstanding, 1);
    req_valid = 1; req_rd = 3; req_xd = 1;
    #1;
    chk("dup_req_ready", req_ready, 0);
    tick();
    chk("dup_req_ready_2", req_ready, 0);
    respond(3, 64'h33);
    chk("dup_res_rd", res_rd, 3);
    chk("dup_res_data", res_data, 64'h33);
    chk("dup_req_ready_after", req_ready, 1);
    tick();
    req_valid = 0;
    io_cmd_ready = 1;
    tick();
    io_cmd_ready = 0;
    chk("dup_outstanding_again", outstanding, 1);
    respond(3, 0);
    chk("dup_outstanding_0", outstanding, 0);
    // no-response command allocates nothing
    send_cmd(12, 1'b0);
    chk("xd0_outstanding", outstanding, 0);
    chk("xd0_cmd_rd", c_rd, 12);
    // unmatched response, held until consumed
    res_ready = 0;
    respond(9, 64'h55);
    chk("unm_res_valid", res_valid, 1);
    chk("unm_res_error", res_error, 1);
    chk("unm_res_latency", res_latency, 0);
    chk("unm_err_sticky", err_sticky, 1);
    chk("unm_resp_ready", io_resp_ready, 0);
    tick();
    chk("unm_hold_valid", res_valid, 1);
    chk("unm_hold_rd", res_rd, 9);
    res_ready = 1;
    tick();
    chk("unm_consumed", res_valid, 0);
    // timeout after 16 cycles in the short-timeout instance
    do_reset();
    chk("t_rst_sticky", t_err_sticky, 0);
    send_cmd(6, 1'b1);
    repeat (14) tick();
    chk("t_pulse_early", t_timeout_pulse, 0);
    tick();
    chk("t_pulse", t_timeout_pulse, 1);
    chk("t_outstanding_1", t_outstanding, 1);
    tick();
    chk("t_pulse_gone", t_timeout_pulse, 0);
    chk("t_outstanding_0", t_outstanding, 0);
    chk("t_sticky", t_err_sticky, 1);
    chk("long_outstanding", outstanding, 1);
    respond(6, 0);
    // response in the timeout cycle wins
    do_reset();
    send_cmd(8, 1'b1);
    repeat (15) tick();
    io_resp_valid = 1; io_resp_bits_rd = 8; io_resp_bits_data = 64'h77;
    #1;
    chk("race_no_pulse", t_timeout_pulse, 0);
    tick();
    io_resp_valid = 0;
    chk("race_res_error", t_res_error, 0);
    chk("race_res_latency", t_res_latency, 16);
    chk("race_res_data", t_res_data, 64'h77);
    chk("race_outstanding", t_outstanding, 0);
    chk("race_sticky", t_err_sticky, 0);
    // reset mid-operation discards entries, result and sticky error
    send_cmd(1, 1'b1);
    send_cmd(2, 1'b1);
    chk("pre_rst_outstanding", outstanding, 2);
    res_ready = 0;
    respond(20, 0);
    chk("pre_rst_res_valid", res_valid, 1);
    chk("pre_rst_sticky", err_sticky, 1);
    reset = 1;
    io_resp_valid = 1; io_resp_bits_rd = 1;
    tick();
    reset = 0;
    io_resp_valid = 0;
    chk("mid_rst_outstanding", outstanding, 0);
    chk("mid_rst_sticky", err_sticky, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    tick();
    chk("mid_rst_resp_dropped", res_valid, 0);
    res_ready = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
